lut3_cell: RTL and testbench

- Configurable 3-input look-up table (LUT3) cell used as the `top` design in the install-flow feature tests.
- Combinational output O = TT[I], where TT is an 8-bit truth-table register.
- TT is initialised from parameter INIT and can be rewritten through a small synchronous configuration port.
- Also provides a registered copy of the output and a readback of TT.

---
 rtl/lut3_cell.sv | 78 +++++++
 tb/tb_lut3_cell.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/lut3_cell.sv
// lut3_cell: configurable 3-input look-up table.
// The 8-bit truth table powers up to INIT, can be rewritten bit-wise through
// a masked synchronous config port, and drives a combinational output plus
// an optional registered copy of that output.
module lut3_cell #(
    parameter logic [7:0] INIT        = 8'h83,
    parameter logic       REG_OUT_RST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] I,
    output logic       O,
    input  logic       cfg_we,
    input  logic [7:0] cfg_wdata,
    input  logic [7:0] cfg_wmask,
    output logic [7:0] cfg_rdata,
    input  logic       oe_q,
    output logic       O_q
);

    // Merge new bits into the table only where the mask is set.
    function automatic logic [7:0] masked_merge(
        input logic [7:0] cur,
        input logic [7:0] wdata,
        input logic [7:0] wmask
    );
        masked_merge = (cur & ~wmask) | (wdata & wmask);
    endfunction

    // The declaration initialisers give the power-up state, so O is valid
    // from time 0 even if clk never toggles and rst is never asserted.
    logic [7:0] tt_q    = INIT;
    logic [7:0] tt_d;
    logic       o_reg_q = REG_OUT_RST;
    logic       o_reg_d;
    logic       lut_s;

    // Table lookup; an X/Z select propagates X to O only.
    always_comb begin
        lut_s = tt_q[I];
    end

    // Next-state for the truth table and output register; reset wins over
    // both the config write and the capture. Capture uses the pre-edge table.
    always_comb begin
        tt_d    = tt_q;
        o_reg_d = o_reg_q;
        if (rst) begin
            tt_d    = INIT;
            o_reg_d = REG_OUT_RST;
        end else begin
            if (cfg_we) begin
                tt_d = masked_merge(tt_q, cfg_wdata, cfg_wmask);
            end else begin
                tt_d = tt_q;
            end
            if (oe_q) begin
                o_reg_d = lut_s;
            end else begin
                o_reg_d = o_reg_q;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        tt_q    <= tt_d;
        o_reg_q <= o_reg_d;
    end

    // Output drive: combinational lookup, readback and registered copy.
    always_comb begin
        O         = lut_s;
        cfg_rdata = tt_q;
        O_q       = o_reg_q;
    end

endmodule

// File: tb/tb_lut3_cell.sv
// Self-checking bench for lut3_cell: directed steps followed by random
// traffic compared against a bit-level reference model of the table.
module tb_lut3_cell;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] I = 3'b000;
    logic       O;
    logic       cfg_we = 1'b0;
    logic [7:0] cfg_wdata = 8'h00;
    logic [7:0] cfg_wmask = 8'h00;
    logic [7:0] cfg_rdata;
    logic       oe_q = 1'b0;
    logic       O_q;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit [7:0] tt_m = 8'h83;
    bit       oq_m = 1'b1;

    lut3_cell #(.INIT(8'h83), .REG_OUT_RST(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .I        (I),
        .O        (O),
        .cfg_we   (cfg_we),
        .cfg_wdata(cfg_wdata),
        .cfg_wmask(cfg_wmask),
        .cfg_rdata(cfg_rdata),
        .oe_q     (oe_q),
        .O_q      (O_q)
    );

    // Gated free-running clock, started after the no-clock checks.
    always #5 clk = clk_en ? ~clk : clk;

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_o(input bit [7:0] tt, input int sel);
        return bit'((tt >> sel) & 8'h01);
    endfunction

    // Apply inputs for one rising edge and advance the model with pre-edge values.
    task automatic edge_step(input logic r, input logic we, input logic [7:0] wd,
                             input logic [7:0] wm, input logic oe, input logic [2:0] sel);
        bit [7:0] tt_n;
        bit       oq_n;
        rst = r; cfg_we = we; cfg_wdata = wd; cfg_wmask = wm; oe_q = oe; I = sel;
        if (r) begin
            tt_n = 8'h83;
            oq_n = 1'b1;
        end else begin
            tt_n = tt_m;
            oq_n = oe ? model_o(tt_m, int'(sel)) : oq_m;
            if (we) begin
                for (int k = 0; k < 8; k++) begin
                    if (wm[k]) tt_n[k] = wd[k];
                end
            end
        end
        @(posedge clk);
        #1;
        tt_m = tt_n;
        oq_m = oq_n;
        rst = 1'b0; cfg_we = 1'b0; oe_q = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_5a;
        bit [2:0] seq_i [8];
        bit       seq_o [8];
        exp_5a = 8'b0101_1010;
        seq_i = '{3'b000, 3'b001, 3'b111, 3'b010, 3'b100, 3'b011, 3'b101, 3'b110};
        seq_o = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Power-up, no clock
        #1;
        check("powerup_rdata", cfg_rdata, 8'h83);
        for (int n = 0; n < 8; n++) begin
            I = seq_i[n];
            #25;
            check($sformatf("default_O_i%0d", seq_i[n]), {7'd0, O}, {7'd0, seq_o[n]});
        end

        // Start clock, reset
        clk_en = 1'b1;
        edge_step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 3'b000);
        check("reset_rdata", cfg_rdata, 8'h83);
        check("reset_Oq", {7'd0, O_q}, 8'h01);

        // Full rewrite to 5A
        edge_step(1'b0, 1'b1, 8'h5A, 8'hFF, 1'b0, 3'b000);
        check("full_rdata", cfg_rdata, 8'h5A);
        for (int n = 0; n < 8; n++) begin
            I = 3'(n);
            #1;
            check($sformatf("full_O_i%0d", n), {7'd0, O}, {7'd0, exp_5a[n]});
        end

        // Masked write from INIT
        edge_step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 3'b000);
        edge_step(1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 3'b000);
        check("mask_rdata", cfg_rdata, 8'h82);
        check("mask_O_i0", {7'd0, O}, 8'h00);
        I = 3'b001; #1;
        check("mask_O_i1", {7'd0, O}, 8'h01);

        // Drive O_q low, then reset together with a full write
        edge_step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 3'b010);
        check("pre_rst_Oq", {7'd0, O_q}, 8'h00);
        edge_step(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 3'b010);
        check("rstprio_rdata", cfg_rdata, 8'h83);
        check("rstprio_Oq", {7'd0, O_q}, 8'h01);

        // Registered path
        edge_step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 3'b111);
        check("reg_111", {7'd0, O_q}, 8'h01);
        edge_step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 3'b010);
        check("reg_010", {7'd0, O_q}, 8'h00);
        edge_step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'b000);
        check("reg_hold", {7'd0, O_q}, 8'h00);

        // Write/capture collision
        edge_step(1'b0, 1'b1, 8'h00, 8'h01, 1'b1, 3'b000);
        check("coll_Oq", {7'd0, O_q}, 8'h01);
        check("coll_O", {7'd0, O}, 8'h00);
        check("coll_rdata", cfg_rdata, 8'h82);

        // Random traffic against the model
        for (int n = 0; n < 300; n++) begin
            logic       r;
            logic       we;
            logic       oe;
            logic [7:0] wd;
            logic [7:0] wm;
            logic [2:0] sel;
            r   = ($urandom_range(0, 19) == 0);
            we  = 1'($urandom_range(0, 1));
            oe  = 1'($urandom_range(0, 1));
            wd  = 8'($urandom);
            wm  = 8'($urandom);
            sel = 3'($urandom_range(0, 7));
            edge_step(r, we, wd, wm, oe, sel);
            check("rnd_rdata", cfg_rdata, tt_m);
            check("rnd_Oq", {7'd0, O_q}, {7'd0, oq_m});
            I = 3'($urandom_range(0, 7));
            #1;
            check("rnd_O", {7'd0, O}, {7'd0, model_o(tt_m, int'(I))});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
